// File: rtl/riscv_axi_rd_arb.sv
// AXI4 read-channel arbiter: merges NUM_CH requester AR/R ports onto one downstream read master.
// ARID is tagged with the channel index and R beats are routed back by that tag.
module riscv_axi_rd_arb #(
    parameter int NUM_CH    = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int ID_W      = 4,
    parameter int MAX_OUTST = 4,
    parameter int ARB_MODE  = 0,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     ACLK,
    input  logic                     ARESETn,
    input  logic [NUM_CH-1:0]        s_arvalid,
    output logic [NUM_CH-1:0]        s_arready,
    input  logic [NUM_CH*ADDR_W-1:0] s_araddr,
    input  logic [NUM_CH*ID_W-1:0]   s_arid,
    input  logic [NUM_CH*8-1:0]      s_arlen,
    output logic [NUM_CH-1:0]        s_rvalid,
    input  logic [NUM_CH-1:0]        s_rready,
    output logic [DATA_W-1:0]        s_rdata,
    output logic [ID_W-1:0]          s_rid,
    output logic [1:0]               s_rresp,
    output logic                     s_rlast,
    output logic                     m_arvalid,
    input  logic                     m_arready,
    output logic [ADDR_W-1:0]        m_araddr,
    output logic [ID_W+CH_W-1:0]     m_arid,
    output logic [7:0]               m_arlen,
    input  logic                     m_rvalid,
    output logic                     m_rready,
    input  logic [DATA_W-1:0]        m_rdata,
    input  logic [ID_W+CH_W-1:0]     m_rid,
    input  logic [1:0]               m_rresp,
    input  logic                     m_rlast,
    output logic                     rid_err
);

    localparam int CNT_W = $clog2(MAX_OUTST + 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_e;

    state_e                  state_q;
    logic                    m_arvalid_q;
    logic [ADDR_W-1:0]       m_araddr_q;
    logic [ID_W+CH_W-1:0]    m_arid_q;
    logic [7:0]              m_arlen_q;
    logic [CH_W-1:0]         rr_q;
    logic                    rid_err_q;
    logic [CNT_W-1:0]        outst_q [NUM_CH];
    logic [CNT_W-1:0]        outst_d [NUM_CH];

    logic [NUM_CH-1:0]       gnt_oh;
    logic                    grant_vld;
    logic [CH_W-1:0]         grant_ch;
    logic [ADDR_W-1:0]       sel_addr;
    logic [ID_W-1:0]         sel_id;
    logic [7:0]              sel_len;

    logic [CH_W-1:0]         r_tag;
    logic                    tag_ok;
    logic [NUM_CH-1:0]       rlast_hs;

    // Scan candidates in priority order (rotated by rr_q in round-robin mode); first eligible wins.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        gnt_oh    = '0;
        grant_vld = 1'b0;
        grant_ch  = '0;
        sel_addr  = '0;
        sel_id    = '0;
        sel_len   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!grant_vld && s_arvalid[i] && (outst_q[i] < CNT_W'(MAX_OUTST)) &&
                    (i == ((ARB_MODE == 1) ? k : (int'(rr_q) + k) % NUM_CH))) begin
                    grant_vld = 1'b1;
                    gnt_oh[i] = 1'b1;
                    grant_ch  = CH_W'(i);
                    sel_addr  = s_araddr[i*ADDR_W +: ADDR_W];
                    sel_id    = s_arid[i*ID_W +: ID_W];
                    sel_len   = s_arlen[i*8 +: 8];
                end
            end
        end
        if ((state_q != ST_IDLE) || !ARESETn) begin
            gnt_oh    = '0;
            grant_vld = 1'b0;
        end
    end

    assign s_arready = gnt_oh;

    // Beats carrying a tag with no matching channel are accepted and discarded.
    assign r_tag  = m_rid[ID_W+CH_W-1:ID_W];
    assign tag_ok = (int'(r_tag) < NUM_CH);

    always_comb begin
        s_rvalid = '0;
        m_rready = 1'b1;
        rlast_hs = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (tag_ok && (int'(r_tag) == i)) begin
                s_rvalid[i] = m_rvalid;
                m_rready    = s_rready[i];
                rlast_hs[i] = m_rvalid & s_rready[i] & m_rlast;
            end
        end
    end

    assign s_rdata = m_rdata;
    assign s_rid   = m_rid[ID_W-1:0];
    assign s_rresp = m_rresp;
    assign s_rlast = m_rlast;

    // A capture and a completion on the same channel in one cycle cancel out.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            outst_d[i] = outst_q[i];
            if (gnt_oh[i] && !rlast_hs[i]) begin
                outst_d[i] = outst_q[i] + 1'b1;
            end else if (!gnt_oh[i] && rlast_hs[i] && (outst_q[i] != '0)) begin
                outst_d[i] = outst_q[i] - 1'b1;
            end
        end
    end

    // NOTE: the counter array is a handful of flops, not a RAM, so it is reset like any register.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            for (int i = 0; i < NUM_CH; i++) outst_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) outst_q[i] <= outst_d[i];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q     <= ST_IDLE;
            m_arvalid_q <= 1'b0;
            m_araddr_q  <= '0;
            m_arid_q    <= '0;
            m_arlen_q   <= '0;
            rr_q        <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_vld) begin
                        state_q     <= ST_ISSUE;
                        m_arvalid_q <= 1'b1;
                        m_araddr_q  <= sel_addr;
                        m_arid_q    <= {grant_ch, sel_id};
                        m_arlen_q   <= sel_len;
                        rr_q        <= (int'(grant_ch) == NUM_CH - 1) ? '0 : grant_ch + 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (m_arready) begin
                        state_q     <= ST_IDLE;
                        m_arvalid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    m_arvalid_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rid_err_q <= 1'b0;
        end else if (m_rvalid && !tag_ok) begin
            rid_err_q <= 1'b1;
        end
    end

    assign m_arvalid = m_arvalid_q;
    assign m_araddr  = m_araddr_q;
    assign m_arid    = m_arid_q;
    assign m_arlen   = m_arlen_q;
    assign rid_err   = rid_err_q;

endmodule

// File: tb/tb_riscv_axi_rd_arb.sv
// Bench for riscv_axi_rd_arb: a round-robin and a fixed-priority instance share all inputs;
// each is compared every cycle against its own behavioural model, plus directed scenarios.
module tb_riscv_axi_rd_arb;

    localparam int N    = 3;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int IW   = 4;
    localparam int CW   = 2;
    localparam int RW   = IW + CW;
    localparam int MAXO = 4;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    s_arvalid;
    logic [N*AW-1:0] s_araddr;
    logic [N*IW-1:0] s_arid;
    logic [N*8-1:0]  s_arlen;
    logic [N-1:0]    s_rready;
    logic            m_arready;
    logic            m_rvalid;
    logic [DW-1:0]   m_rdata;
    logic [RW-1:0]   m_rid;
    logic [1:0]      m_rresp;
    logic            m_rlast;

    logic [N-1:0]    s_arready_o [2];
    logic [N-1:0]    s_rvalid_o  [2];
    logic [DW-1:0]   s_rdata_o   [2];
    logic [IW-1:0]   s_rid_o     [2];
    logic [1:0]      s_rresp_o   [2];
    logic            s_rlast_o   [2];
    logic            m_arvalid_o [2];
    logic [AW-1:0]   m_araddr_o  [2];
    logic [RW-1:0]   m_arid_o    [2];
    logic [7:0]      m_arlen_o   [2];
    logic            m_rready_o  [2];
    logic            rid_err_o   [2];

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state; index 0 = round robin, 1 = fixed priority.
    bit            mdl_issue [2];
    logic [AW-1:0] mdl_addr  [2];
    logic [RW-1:0] mdl_id    [2];
    logic [7:0]    mdl_len   [2];
    int            mdl_rr    [2];
    int            mdl_outst [2][N];
    bit            mdl_rerr  [2];
    logic [N-1:0]  seen_ar   [2];

    riscv_axi_rd_arb #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW),
                       .MAX_OUTST(MAXO), .ARB_MODE(0)) u_rr (
        .ACLK(clk), .ARESETn(rst_n),
        .s_arvalid(s_arvalid), .s_arready(s_arready_o[0]), .s_araddr(s_araddr),
        .s_arid(s_arid), .s_arlen(s_arlen),
        .s_rvalid(s_rvalid_o[0]), .s_rready(s_rready), .s_rdata(s_rdata_o[0]),
        .s_rid(s_rid_o[0]), .s_rresp(s_rresp_o[0]), .s_rlast(s_rlast_o[0]),
        .m_arvalid(m_arvalid_o[0]), .m_arready(m_arready), .m_araddr(m_araddr_o[0]),
        .m_arid(m_arid_o[0]), .m_arlen(m_arlen_o[0]),
        .m_rvalid(m_rvalid), .m_rready(m_rready_o[0]), .m_rdata(m_rdata),
        .m_rid(m_rid), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .rid_err(rid_err_o[0])
    );

    riscv_axi_rd_arb #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW),
                       .MAX_OUTST(MAXO), .ARB_MODE(1)) u_fp (
        .ACLK(clk), .ARESETn(rst_n),
        .s_arvalid(s_arvalid), .s_arready(s_arready_o[1]), .s_araddr(s_araddr),
        .s_arid(s_arid), .s_arlen(s_arlen),
        .s_rvalid(s_rvalid_o[1]), .s_rready(s_rready), .s_rdata(s_rdata_o[1]),
        .s_rid(s_rid_o[1]), .s_rresp(s_rresp_o[1]), .s_rlast(s_rlast_o[1]),
        .m_arvalid(m_arvalid_o[1]), .m_arready(m_arready), .m_araddr(m_araddr_o[1]),
        .m_arid(m_arid_o[1]), .m_arlen(m_arlen_o[1]),
        .m_rvalid(m_rvalid), .m_rready(m_rready_o[1]), .m_rdata(m_rdata),
        .m_rid(m_rid), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .rid_err(rid_err_o[1])
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, obs, exp);
        end
    endtask

    function automatic int rtag();
        return int'(m_rid[RW-1:IW]);
    endfunction

    // Channel the model would grant this cycle, or -1.
    function automatic int model_grant(input int d);
        int c;
        if (!rst_n || mdl_issue[d]) return -1;
        for (int k = 0; k < N; k++) begin
            c = (d == 1) ? k : (mdl_rr[d] + k) % N;
            if (s_arvalid[c] && mdl_outst[d][c] < MAXO) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            mdl_issue[d] = 0;
            mdl_addr[d]  = '0;
            mdl_id[d]    = '0;
            mdl_len[d]   = '0;
            mdl_rr[d]    = 0;
            mdl_rerr[d]  = 0;
            for (int c = 0; c < N; c++) mdl_outst[d][c] = 0;
        end
    endtask

    task automatic model_update();
        int g, inc, dec, tag;
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int d = 0; d < 2; d++) begin
            g   = model_grant(d);
            inc = -1;
            dec = -1;
            if (mdl_issue[d]) begin
                if (m_arready) mdl_issue[d] = 0;
            end else if (g >= 0) begin
                mdl_issue[d] = 1;
                mdl_addr[d]  = s_araddr[g*AW +: AW];
                mdl_id[d]    = {CW'(g), s_arid[g*IW +: IW]};
                mdl_len[d]   = s_arlen[g*8 +: 8];
                mdl_rr[d]    = (g + 1) % N;
                inc          = g;
            end
            tag = rtag();
            if (m_rvalid) begin
                if (tag >= N) mdl_rerr[d] = 1;
                else if (s_rready[tag] && m_rlast) dec = tag;
            end
            for (int c = 0; c < N; c++) begin
                if (inc == c && dec == c) begin
                end else if (inc == c) begin
                    mdl_outst[d][c]++;
                end else if (dec == c && mdl_outst[d][c] > 0) begin
                    mdl_outst[d][c]--;
                end
            end
        end
    endtask

    // Compare every output of both instances against the model, away from the clock edge.
    task automatic settle();
        int g, tag;
        logic [N-1:0] exp_ar, exp_rv;
        logic exp_rr;
        #1;
        tag = rtag();
        for (int d = 0; d < 2; d++) begin
            g      = model_grant(d);
            exp_ar = '0;
            if (g >= 0) exp_ar[g] = 1'b1;
            exp_rv = '0;
            exp_rr = 1'b1;
            if (tag < N) begin
                exp_rv[tag] = m_rvalid;
                exp_rr      = s_rready[tag];
            end
            seen_ar[d] = s_arready_o[d];
            check($sformatf("d%0d s_arready", d), s_arready_o[d], exp_ar);
            check($sformatf("d%0d s_rvalid", d),  s_rvalid_o[d],  exp_rv);
            check($sformatf("d%0d m_rready", d),  m_rready_o[d],  exp_rr);
            check($sformatf("d%0d s_rdata", d),   s_rdata_o[d],   m_rdata);
            check($sformatf("d%0d s_rid", d),     s_rid_o[d],     m_rid[IW-1:0]);
            check($sformatf("d%0d s_rresp", d),   s_rresp_o[d],   m_rresp);
            check($sformatf("d%0d s_rlast", d),   s_rlast_o[d],   m_rlast);
            check($sformatf("d%0d m_arvalid", d), m_arvalid_o[d], mdl_issue[d]);
            check($sformatf("d%0d m_araddr", d),  m_araddr_o[d],  mdl_addr[d]);
            check($sformatf("d%0d m_arid", d),    m_arid_o[d],    mdl_id[d]);
            check($sformatf("d%0d m_arlen", d),   m_arlen_o[d],   mdl_len[d]);
            check($sformatf("d%0d rid_err", d),   rid_err_o[d],   mdl_rerr[d]);
        end
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic tick();
        settle();
        advance();
    endtask

    task automatic idle_inputs();
        s_arvalid = '0;
        s_araddr  = '0;
        s_arid    = '0;
        s_arlen   = '0;
        s_rready  = '1;
        m_arready = 1'b1;
        m_rvalid  = 1'b0;
        m_rdata   = '0;
        m_rid     = '0;
        m_rresp   = '0;
        m_rlast   = 1'b0;
    endtask

    task automatic set_req(input int c, input logic [AW-1:0] a, input logic [IW-1:0] id,
                           input logic [7:0] len);
        s_arvalid[c]          = 1'b1;
        s_araddr[c*AW +: AW]  = a;
        s_arid[c*IW +: IW]    = id;
        s_arlen[c*8 +: 8]     = len;
    endtask

    task automatic rand_inputs(input int rlast_pct);
        int tag;
        for (int c = 0; c < N; c++) begin
            s_arvalid[c]         = ($urandom_range(99) < 60);
            s_araddr[c*AW +: AW] = $urandom();
            s_arid[c*IW +: IW]   = IW'($urandom());
            s_arlen[c*8 +: 8]    = 8'($urandom());
            s_rready[c]          = ($urandom_range(99) < 75);
        end
        m_arready = ($urandom_range(99) < 70);
        m_rvalid  = ($urandom_range(99) < 50);
        m_rdata   = $urandom();
        m_rresp   = 2'($urandom());
        m_rlast   = ($urandom_range(99) < rlast_pct);
        tag       = ($urandom_range(15) == 0) ? 3 : $urandom_range(2);
        m_rid     = {CW'(tag), IW'($urandom())};
    endtask

    initial begin
        int gq [2][$];
        int ng [2];

        clk   = 1'b0;
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        repeat (3) tick();
        rst_n = 1'b1;

        // Single request on ch1, then its R beat.
        set_req(1, 32'h1000, 4'h3, 8'h00);
        settle();
        for (int d = 0; d < 2; d++) check($sformatf("single grant d%0d", d), s_arready_o[d], 3'b010);
        advance();
        s_arvalid = '0;
        settle();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("single m_arvalid d%0d", d), m_arvalid_o[d], 1'b1);
            check($sformatf("single m_araddr d%0d", d),  m_araddr_o[d],  32'h1000);
            check($sformatf("single m_arid d%0d", d),    m_arid_o[d],    6'h13);
        end
        advance();
        m_rvalid = 1'b1;
        m_rid    = 6'h13;
        m_rlast  = 1'b1;
        m_rdata  = 32'hCAFE_0001;
        settle();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("single s_rvalid d%0d", d), s_rvalid_o[d], 3'b010);
            check($sformatf("single s_rid d%0d", d),    s_rid_o[d],    4'h3);
        end
        advance();
        idle_inputs();

        // ch0 and ch1 requesting continuously.
        set_req(0, 32'h2000, 4'h1, 8'h00);
        set_req(1, 32'h3000, 4'h2, 8'h01);
        for (int cyc = 0; cyc < 8; cyc++) begin
            settle();
            for (int d = 0; d < 2; d++)
                if (seen_ar[d] != '0) gq[d].push_back($clog2(seen_ar[d]));
            advance();
        end
        check("rr grant count", gq[0].size(), 4);
        check("fp grant count", gq[1].size(), 4);
        for (int i = 0; i < 4 && i < gq[0].size(); i++) check($sformatf("rr grant %0d", i), gq[0][i], i % 2);
        for (int i = 0; i < 4 && i < gq[1].size(); i++) check($sformatf("fp grant %0d", i), gq[1][i], 0);
        s_arvalid = '0;
        repeat (2) tick();

        // Reset asserted while an AR is held in ISSUE.
        set_req(1, 32'h4000, 4'h5, 8'h03);
        tick();
        s_arvalid = '0;
        m_arready = 1'b0;
        tick();
        rst_n     = 1'b0;
        s_arvalid = '1;
        model_reset();
        settle();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset m_arvalid d%0d", d), m_arvalid_o[d], 1'b0);
            check($sformatf("reset s_arready d%0d", d), s_arready_o[d], 3'b000);
            check($sformatf("reset rid_err d%0d", d),   rid_err_o[d],   1'b0);
        end
        advance();
        tick();
        rst_n = 1'b1;
        idle_inputs();
        set_req(1, 32'h4100, 4'h6, 8'h00);
        set_req(2, 32'h4200, 4'h7, 8'h00);
        settle();
        check("rr pointer after reset", s_arready_o[0], 3'b010);
        advance();
        s_arvalid = '0;
        tick();

        // Outstanding limit on ch0.
        set_req(0, 32'h5000, 4'h0, 8'h00);
        ng[0] = 0;
        ng[1] = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            settle();
            for (int d = 0; d < 2; d++) if (seen_ar[d][0]) ng[d]++;
            advance();
        end
        for (int d = 0; d < 2; d++) check($sformatf("limit grants d%0d", d), ng[d], MAXO);
        for (int cyc = 0; cyc < 2; cyc++) begin
            settle();
            for (int d = 0; d < 2; d++) check($sformatf("limit blocked d%0d", d), s_arready_o[d], 3'b000);
            advance();
        end
        m_rvalid = 1'b1;
        m_rid    = 6'h00;
        m_rlast  = 1'b1;
        settle();
        for (int d = 0; d < 2; d++) check($sformatf("limit still full d%0d", d), s_arready_o[d], 3'b000);
        advance();
        m_rvalid = 1'b0;
        settle();
        for (int d = 0; d < 2; d++) check($sformatf("limit released d%0d", d), s_arready_o[d], 3'b001);
        advance();

        // Capture and completion for ch0 in the same cycle at 3 outstanding.
        s_arvalid = '0;
        tick();
        m_rvalid = 1'b1;
        tick();
        s_arvalid[0] = 1'b1;
        settle();
        for (int d = 0; d < 2; d++) check($sformatf("simul grant d%0d", d), s_arready_o[d], 3'b001);
        advance();
        m_rvalid     = 1'b0;
        s_arvalid[0] = 1'b0;
        tick();
        s_arvalid[0] = 1'b1;
        settle();
        for (int d = 0; d < 2; d++) check($sformatf("simul 4th d%0d", d), s_arready_o[d], 3'b001);
        advance();
        tick();
        settle();
        for (int d = 0; d < 2; d++) check($sformatf("simul full d%0d", d), s_arready_o[d], 3'b000);
        advance();
        idle_inputs();
        tick();

        // AR backpressure: m_ar* hold while inputs change.
        set_req(1, 32'h6000, 4'h7, 8'h0F);
        m_arready = 1'b0;
        tick();
        for (int cyc = 0; cyc < 5; cyc++) begin
            s_araddr[AW +: AW] = $urandom();
            s_arlen[8 +: 8]    = 8'($urandom());
            settle();
            for (int d = 0; d < 2; d++) begin
                check($sformatf("hold m_arvalid d%0d", d), m_arvalid_o[d], 1'b1);
                check($sformatf("hold m_araddr d%0d", d),  m_araddr_o[d],  32'h6000);
                check($sformatf("hold m_arid d%0d", d),    m_arid_o[d],    6'h17);
                check($sformatf("hold m_arlen d%0d", d),   m_arlen_o[d],   8'h0F);
            end
            advance();
        end
        m_arready = 1'b1;
        s_arvalid = '0;
        tick();

        // R backpressure and bad tag.
        m_rvalid = 1'b1;
        m_rid    = 6'h17;
        m_rlast  = 1'b0;
        s_rready = 3'b101;
        settle();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("r bp m_rready d%0d", d), m_rready_o[d], 1'b0);
            check($sformatf("r bp s_rvalid d%0d", d), s_rvalid_o[d], 3'b010);
        end
        advance();
        m_rid    = 6'h32;
        s_rready = '1;
        settle();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("bad tag s_rvalid d%0d", d), s_rvalid_o[d], 3'b000);
            check($sformatf("bad tag m_rready d%0d", d), m_rready_o[d], 1'b1);
        end
        advance();
        m_rvalid = 1'b0;
        settle();
        for (int d = 0; d < 2; d++) check($sformatf("bad tag rid_err d%0d", d), rid_err_o[d], 1'b1);
        advance();

        // Randomized traffic: slow completions first to reach the limit, then fast.
        rst_n = 1'b0;
        model_reset();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            rand_inputs((i < 700) ? 10 : 60);
            if (i == 900) begin
                rst_n = 1'b0;
                model_reset();
            end
            if (i == 902) rst_n = 1'b1;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
